// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : Instruction fetch stage. Owns the PC, issues one word fetch at a
//            time over a req/gnt/rvalid handshake, and holds the returned word
//            in an IF/ID output register with decoded field slices. Supports
//            downstream stall (one-entry skid buffer) and redirect with flush.
// Ports    : clk, reset           - clock, synchronous active-high reset
//            imem_req/imem_addr   - fetch request and word-aligned address
//            imem_gnt             - request accepted this cycle
//            imem_rvalid/rdata    - response strobe and instruction word
//            stall                - downstream holds the output register
//            redirect/redirect_pc - taken branch/jump; flush and refetch
//            instr_valid/instr/instr_pc - IF/ID output register
//            op/func/rs/rt/rd/imm - field slices of instr
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [5:0]  op,
  output logic [5:0]  func,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] imm
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_FULL = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_discard;
  logic        w_discard_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_req_pc;
  logic        r_valid;
  logic [31:0] r_instr;
  logic [31:0] r_instr_pc;
  logic [31:0] r_skid_instr;
  logic [31:0] r_skid_pc;

  logic        w_consume;
  logic        w_slot_free;
  logic        w_grant;
  logic        w_load_resp;
  logic        w_load_skid;
  logic        w_fill_skid;
  logic        w_unused;

  // Low redirect address bits are forced to zero, never used.
  assign w_unused    = ^redirect_pc[1:0];

  assign w_consume   = r_valid & ~stall;
  assign w_slot_free = ~r_valid | w_consume;
  assign w_grant     = (r_state == S_REQ) & imem_gnt;

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_REQ;
      r_discard <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_discard <= w_discard_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state and datapath strobes
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    w_discard_nxt = r_discard;
    w_load_resp   = 1'b0;
    w_load_skid   = 1'b0;
    w_fill_skid   = 1'b0;
    imem_req      = 1'b0;

    case (r_state)
      S_REQ: begin
        imem_req = 1'b1;
        if (imem_gnt) begin
          w_state_nxt = S_WAIT;
          // A grant in the redirect cycle fetched the old path; drop its reply.
          if (redirect) w_discard_nxt = 1'b1;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          w_state_nxt   = S_REQ;
          w_discard_nxt = 1'b0;
          if (!redirect && !r_discard) begin
            if (w_slot_free) begin
              w_load_resp = 1'b1;
            end else begin
              w_fill_skid = 1'b1;
              w_state_nxt = S_FULL;
            end
          end
        end else if (redirect) begin
          // Response still in flight belongs to the old path.
          w_discard_nxt = 1'b1;
        end
      end
      S_FULL: begin
        if (redirect) begin
          w_state_nxt = S_REQ;
        end else if (w_consume) begin
          w_load_skid = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      default: begin
        w_state_nxt   = S_REQ;
        w_discard_nxt = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // PC, output register and skid buffer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc         <= RESET_PC;
      r_req_pc     <= 32'h0;
      r_valid      <= 1'b0;
      r_instr      <= 32'h0;
      r_instr_pc   <= 32'h0;
      r_skid_instr <= 32'h0;
      r_skid_pc    <= 32'h0;
    end else begin
      if (redirect) begin
        r_pc <= {redirect_pc[31:2], 2'b00};
      end else if (w_grant) begin
        r_pc <= r_pc + 32'd4;
      end

      if (w_grant) begin
        r_req_pc <= r_pc;
      end

      if (redirect) begin
        r_valid <= 1'b0;
      end else if (w_load_resp) begin
        r_valid    <= 1'b1;
        r_instr    <= imem_rdata;
        r_instr_pc <= r_req_pc;
      end else if (w_load_skid) begin
        r_valid    <= 1'b1;
        r_instr    <= r_skid_instr;
        r_instr_pc <= r_skid_pc;
      end else if (w_consume) begin
        r_valid <= 1'b0;
      end

      if (redirect) begin
        r_skid_instr <= 32'h0;
        r_skid_pc    <= 32'h0;
      end else if (w_fill_skid) begin
        r_skid_instr <= imem_rdata;
        r_skid_pc    <= r_req_pc;
      end
    end
  end

  assign imem_addr   = r_pc;
  assign instr_valid = r_valid;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign op          = r_instr[31:26];
  assign func        = r_instr[5:0];
  assign rs          = r_instr[25:21];
  assign rt          = r_instr[20:16];
  assign rd          = r_instr[15:11];
  assign imm         = r_instr[15:0];

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction fetch stage that sits directly upstream of the controller. It owns the PC and issues word fetches to instruction memory over a request/grant/response handshake. It holds the fetched word in an IF/ID output register and presents decoded fields (op, func, rs, rt, rd, imm) to the controller and register file. It supports downstream stall, a one-entry skid buffer, and branch/jump redirect with flush.

Parameters:
RESET_PC, 32'h00000000, PC loaded on reset (bits [1:0] must be 0)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
imem_req  output  1  fetch request valid
imem_addr  output  32  fetch byte address, word aligned
imem_gnt  input  1  request accepted this cycle
imem_rvalid  input  1  response data valid
imem_rdata  input  32  response instruction word
stall  input  1  downstream cannot accept; hold output register
redirect  input  1  branch/jump taken; flush and refetch
redirect_pc  input  32  new PC; bits [1:0] ignored (forced 0)
instr_valid  output  1  output register holds a valid instruction
instr  output  32  registered instruction word
instr_pc  output  32  address of instr
op  output  6  instr[31:26]
func  output  6  instr[5:0]
rs  output  5  instr[25:21]
rt  output  5  instr[20:16]
rd  output  5  instr[15:11]
imm  output  16  instr[15:0]

Behaviour:
- One clock, clk. reset is synchronous and active-high. On reset: pc_q=RESET_PC; state=REQ; discard=0; instr_valid=0; instr=0; instr_pc=0; skid empty. op/func/rs/rt/rd/imm therefore read 0, which the controller decodes as its default or no-op.
- Field outputs are combinational slices of the registered instr.
- Consume: any cycle with instr_valid=1 and stall=0. The output slot is free when instr_valid=0 or a consume occurs in that cycle.
- At most one fetch is outstanding. States:
  - REQ: imem_req=1 and imem_addr=pc_q. On imem_gnt: req_pc<=pc_q; pc_q<=pc_q+4 (32-bit wrap, FFFFFFFC->00000000); go to WAIT. Without a grant, hold the request stable.
  - WAIT: imem_req=0. On imem_rvalid:
    - If discard=1: clear discard, go to REQ.
    - Else, if the slot is free: instr<=imem_rdata, instr_pc<=req_pc, instr_valid<=1, go to REQ.
    - Else: store the word and req_pc in the skid buffer, go to FULL.
  - FULL: imem_req=0. On consume: load the skid contents into the output register, go to REQ.
- A consume with no new load clears instr_valid.
- imem_rvalid outside WAIT is ignored.
- Redirect has priority over stall and normal flow. In the cycle redirect=1:
  - pc_q<={redirect_pc[31:2],2'b00}.
  - instr_valid<=0 on the next edge (flush). Skid is cleared.
  - REQ with no gnt: stay in REQ. The new address appears next cycle; changing address only on redirect is allowed.
  - REQ with gnt in the same cycle: go to WAIT with discard=1. pc_q takes redirect_pc, not +4.
  - WAIT with no rvalid: discard<=1, stay in WAIT.
  - WAIT with rvalid in the same cycle: drop the data, go to REQ.
  - FULL: go to REQ.
- Minimum latency: gnt in the REQ cycle, rvalid the next cycle, instr_valid the cycle after. Peak throughput is one instruction per 2 cycles.
- Reset mid-operation wins over everything. An in-flight response arriving after reset is ignored, because rvalid is ignored in REQ.
- Stall never changes pc_q or the output register. The held instruction stays bit-stable until consumed or flushed.

Test Plan:
1. Reset, RESET_PC=32'h00400000, reset low: next cycle imem_req=1, imem_addr=32'h00400000; instr_valid=0, op=0, func=0.
2. Streaming, gnt always 1, rvalid 1 cycle after grant, data 32'h00851020 then 32'h8C430004:
   - First word: instr_valid=1, op=0, func=6'h20, rs=4, rt=5, rd=2, instr_pc=32'h00400000.
   - Second word: op=6'h23, imm=16'h0004, instr_pc=32'h00400004.
   - Next fetch address is 32'h00400008.
3. Stall=1 held while the next response arrives: instr unchanged, state FULL, imem_req=0. Release stall: the skid word appears the cycle after the consume, then fetch resumes at the correct PC with no loss or reorder.
4. Redirect during WAIT, redirect_pc=32'h00400100: instr_valid=0 next cycle; the late rvalid data 32'hDEADBEEF never appears on instr; the next imem_addr is 32'h00400100.
5. Redirect in the same cycle as gnt, and separately the same cycle as rvalid: the stale word is dropped in both cases; the next request goes to redirect_pc. Also apply redirect_pc=32'h00400103: address is 32'h00400100.
6. Wrap and reset: redirect to 32'hFFFFFFFC, fetch, next imem_addr=32'h00000000. Assert reset while in WAIT: next cycle state REQ, imem_addr=RESET_PC, instr_valid=0; a following rvalid is ignored.
